// File: rtl/input_signal_check.sv
// Receive-stream sanity checker: locks onto the 0,0,A,A training pattern and counts word/bit errors while locked.
// Optional feature macro: INPUT_SIGNAL_CHECK_BITERR_EN (per-bit error counting via popcount).
module input_signal_check #(
    parameter int LOCK_COUNT = 8,
    parameter int LOSS_COUNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic             radio_clk,
    input  logic             radio_rst_n,
    input  logic [31:0]      rx,
    input  logic             rx_stb,
    input  logic             clear,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] bit_err_cnt
);

    localparam logic [31:0] PAT_A  = 32'hAAAA_AAAA;
    localparam logic [31:0] PAT_Z  = 32'h0000_0000;
    localparam logic [7:0]  LOCK_N = 8'(LOCK_COUNT);
    localparam logic [7:0]  LOSS_N = 8'(LOSS_COUNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [31:0]      prev_q, prev_d;
    logic [7:0]       good_q, good_d;
    logic [7:0]       miss_q, miss_d;
    logic             locked_q, locked_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [31:0]      expected;
    logic             match;
    logic             count_err;

    assign expected = phase_q[1] ? PAT_A : PAT_Z;
    assign match    = (rx == expected);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        prev_d    = prev_q;
        good_d    = good_q;
        miss_d    = miss_q;
        count_err = 1'b0;
        if (rx_stb) begin
            prev_d  = rx;
            phase_d = phase_q + 2'd1;
            case (state_q)
                SEARCH: begin
                    // The A that follows a zero sits at phase 2, so phase 3 is expected next.
                    if (rx == PAT_A && prev_q == PAT_Z) begin
                        phase_d = 2'd3;
                        good_d  = 8'd1;
                        miss_d  = 8'd0;
                        state_d = (LOCK_N == 8'd1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (match) begin
                        good_d = good_q + 8'd1;
                        if (good_q + 8'd1 >= LOCK_N) begin
                            state_d = LOCKED;
                            miss_d  = 8'd0;
                        end
                    end else begin
                        good_d  = 8'd0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_d = 8'd0;
                    end else begin
                        count_err = 1'b1;
                        miss_d    = miss_q + 8'd1;
                        if (miss_q + 8'd1 >= LOSS_N) begin
                            state_d = SEARCH;
                            miss_d  = 8'd0;
                            good_d  = 8'd0;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if (count_err && err_q != '1) err_d = err_q + 1'b1;
        if (clear) err_d = '0;
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge radio_clk or negedge radio_rst_n) begin
        if (!radio_rst_n) begin
            state_q  <= SEARCH;
            phase_q  <= 2'd0;
            prev_q   <= 32'hFFFF_FFFF;
            good_q   <= 8'd0;
            miss_q   <= 8'd0;
            locked_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            prev_q   <= prev_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign locked  = locked_q;
    assign err_cnt = err_q;

`ifdef INPUT_SIGNAL_CHECK_BITERR_EN
    localparam int SW = ERR_W + 7;

    logic [31:0]      diff;
    logic [5:0]       pop;
    logic [SW-1:0]    bit_sum;
    logic [ERR_W-1:0] bit_err_q, bit_err_d;

    assign diff = rx ^ expected;

    always_comb begin
        pop = 6'd0;
        for (int i = 0; i < 32; i++) pop = pop + 6'(diff[i]);
    end

    // Wide sum so a full 32-bit miss saturates cleanly even for narrow counters.
    always_comb begin
        bit_sum   = SW'(bit_err_q) + SW'(pop);
        bit_err_d = bit_err_q;
        if (count_err) begin
            if (bit_sum > SW'({ERR_W{1'b1}})) bit_err_d = '1;
            else                               bit_err_d = bit_sum[ERR_W-1:0];
        end
        if (clear) bit_err_d = '0;
    end

    always_ff @(posedge radio_clk or negedge radio_rst_n) begin
        if (!radio_rst_n) bit_err_q <= '0;
        else              bit_err_q <= bit_err_d;
    end

    assign bit_err_cnt = bit_err_q;
`else
    assign bit_err_cnt = '0;
`endif

endmodule

// File: tb/tb_input_signal_check.sv
// Directed bench for input_signal_check: lock, error counting, loss/relock, strobe gaps, saturation, reset.
module tb_input_signal_check;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic [31:0] rx     = 32'h0;
    logic        stb_a  = 1'b0;
    logic        stb_b  = 1'b0;
    logic        clear  = 1'b0;

    logic        locked_a;
    logic [15:0] err_a, berr_a;
    logic        locked_b;
    logic [3:0]  err_b, berr_b;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] A = 32'hAAAA_AAAA;
`ifdef INPUT_SIGNAL_CHECK_BITERR_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    input_signal_check u_dut (
        .radio_clk(clk), .radio_rst_n(rst_n), .rx(rx), .rx_stb(stb_a), .clear(clear),
        .locked(locked_a), .err_cnt(err_a), .bit_err_cnt(berr_a)
    );

    input_signal_check #(.LOCK_COUNT(8), .LOSS_COUNT(255), .ERR_W(4)) u_sat (
        .radio_clk(clk), .radio_rst_n(rst_n), .rx(rx), .rx_stb(stb_b), .clear(clear),
        .locked(locked_b), .err_cnt(err_b), .bit_err_cnt(berr_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ideal(int k);
        return ((k % 4) >= 2) ? A : 32'h0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(bit d, logic [31:0] v);
        rx = v;
        if (d) stb_b = 1'b1; else stb_a = 1'b1;
        @(posedge clk); #1;
        stb_a = 1'b0;
        stb_b = 1'b0;
        rx    = $urandom;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_locked", 32'(locked_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_berr", 32'(berr_a), 32'd0);
        chk("rst_sat_locked", 32'(locked_b), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();

        // Ideal stream: sync on k=2, lock on the 8th good word (k=9).
        for (int k = 0; k <= 8; k++) send(0, ideal(k));
        chk("lock_early", 32'(locked_a), 32'd0);
        send(0, ideal(9));
        chk("lock_on", 32'(locked_a), 32'd1);
        chk("lock_err", 32'(err_a), 32'd0);

        // Single-bit error in an A slot.
        send(0, 32'hAAAA_AAAB);
        chk("one_err", 32'(err_a), 32'd1);
        chk("one_berr", 32'(berr_a), BE ? 32'd1 : 32'd0);
        chk("one_locked", 32'(locked_a), 32'd1);
        send(0, ideal(11));

        clear = 1'b1; idle(); clear = 1'b0;
        chk("clr_err", 32'(err_a), 32'd0);
        chk("clr_berr", 32'(berr_a), 32'd0);
        chk("clr_locked", 32'(locked_a), 32'd1);

        // Four fully inverted words force loss of lock.
        for (int k = 12; k <= 14; k++) send(0, ~ideal(k));
        chk("loss3_locked", 32'(locked_a), 32'd1);
        chk("loss3_err", 32'(err_a), 32'd3);
        send(0, ~ideal(15));
        chk("loss4_locked", 32'(locked_a), 32'd0);
        chk("loss4_err", 32'(err_a), 32'd4);
        chk("loss4_berr", 32'(berr_a), BE ? 32'd128 : 32'd0);

        for (int k = 16; k <= 24; k++) send(0, ideal(k));
        chk("relock_early", 32'(locked_a), 32'd0);
        chk("relock_err", 32'(err_a), 32'd4);
        send(0, ideal(25));
        chk("relock_on", 32'(locked_a), 32'd1);

        // Asynchronous reset mid-lock, checked between clock edges.
        rst_n = 1'b0;
        #2;
        chk("arst_locked", 32'(locked_a), 32'd0);
        chk("arst_err", 32'(err_a), 32'd0);
        chk("arst_berr", 32'(berr_a), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Strobe toggling with junk on idle cycles.
        for (int k = 0; k <= 9; k++) begin
            send(0, ideal(k));
            if (k == 8) chk("gap_lock_early", 32'(locked_a), 32'd0);
            if (k == 9) chk("gap_lock_on", 32'(locked_a), 32'd1);
            idle();
        end
        chk("gap_err", 32'(err_a), 32'd0);

        // Narrow counter saturation on the second instance.
        for (int k = 0; k <= 9; k++) send(1, ideal(k));
        chk("sat_locked", 32'(locked_b), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            send(1, 32'hFFFF_FFFF);
            if (i == 14) chk("sat_err14", 32'(err_b), 32'd14);
            if (i == 15) chk("sat_err15", 32'(err_b), 32'd15);
        end
        chk("sat_err_hold", 32'(err_b), 32'd15);
        chk("sat_berr", 32'(berr_b), BE ? 32'd15 : 32'd0);
        chk("sat_locked_hold", 32'(locked_b), 32'd1);
        clear = 1'b1; idle(); clear = 1'b0;
        chk("sat_clr_err", 32'(err_b), 32'd0);
        chk("sat_clr_berr", 32'(berr_b), 32'd0);
        chk("sat_clr_locked", 32'(locked_b), 32'd1);
        clear = 1'b1;
        send(1, 32'hFFFF_FFFF);
        clear = 1'b0;
        chk("clr_wins", 32'(err_b), 32'd0);
        send(1, 32'hFFFF_FFFF);
        chk("post_clr_err", 32'(err_b), 32'd1);
        chk("main_undisturbed", 32'(locked_a), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
